// File: rtl/cpu_mdu_dispatch.sv
// == cpu_mdu_dispatch : in-order queue + start/ready sequencer in front of cpu_mdu; optional flush via MDU_DISPATCH_FLUSH_EN ==
// == rev 1.0 ==
`default_nettype none

module cpu_mdu_dispatch #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
`ifdef MDU_DISPATCH_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_control,
  input  logic [XLEN-1:0] in_operand_a,
  input  logic [XLEN-1:0] in_operand_b,
  input  logic [4:0]      in_rd,
  output logic            mdu_start,
  output logic [2:0]      mdu_control,
  output logic [XLEN-1:0] mdu_operand_a,
  output logic [XLEN-1:0] mdu_operand_b,
  input  logic [XLEN-1:0] mdu_result,
  input  logic            mdu_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

`ifdef MDU_DISPATCH_FLUSH_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DONE = 2'd2, S_DRAIN = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DONE = 2'd2} state_t;
`endif

  state_t state, state_nxt;

  logic [2:0]      q_ctrl [DEPTH];
  logic [XLEN-1:0] q_a    [DEPTH];
  logic [XLEN-1:0] q_b    [DEPTH];
  logic [4:0]      q_rd   [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  logic [2:0]      op_ctrl;
  logic [XLEN-1:0] op_a, op_b;
  logic [4:0]      op_rd;

  logic flush_now, push, pop;

`ifdef MDU_DISPATCH_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  always_comb begin
    in_ready = (count < FULL_COUNT);
`ifdef MDU_DISPATCH_FLUSH_EN
    if (state == S_DRAIN) in_ready = 1'b0;
`endif
  end

  // A flushing cycle neither accepts new work nor issues queued work.
  assign push = in_valid & in_ready & ~flush_now;
  assign pop  = (state == S_IDLE) & (count != '0) & ~flush_now;

  always_ff @(posedge clk) begin
    if (reset || flush_now) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_ctrl[wr_ptr] <= in_control;
      q_a[wr_ptr]    <= in_operand_a;
      q_b[wr_ptr]    <= in_operand_b;
      q_rd[wr_ptr]   <= in_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_ctrl <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_rd   <= '0;
    end else if (pop) begin
      op_ctrl <= q_ctrl[rd_ptr];
      op_a    <= q_a[rd_ptr];
      op_b    <= q_b[rd_ptr];
      op_rd   <= q_rd[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_result <= '0;
      out_rd     <= '0;
    end else if ((state == S_ISSUE) && mdu_ready && !flush_now) begin
      out_result <= mdu_result;
      out_rd     <= op_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pop) state_nxt = S_ISSUE;
      S_ISSUE: begin
`ifdef MDU_DISPATCH_FLUSH_EN
        // An op already inside cpu_mdu must run to completion before the next start.
        if (flush_now)      state_nxt = mdu_ready ? S_IDLE : S_DRAIN;
        else if (mdu_ready) state_nxt = S_DONE;
`else
        if (mdu_ready) state_nxt = S_DONE;
`endif
      end
      S_DONE:  if (out_ready || flush_now) state_nxt = S_IDLE;
`ifdef MDU_DISPATCH_FLUSH_EN
      S_DRAIN: if (mdu_ready) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef MDU_DISPATCH_FLUSH_EN
  assign mdu_start = (state == S_ISSUE) || (state == S_DRAIN);
`else
  assign mdu_start = (state == S_ISSUE);
`endif
  assign out_valid     = (state == S_DONE);
  assign mdu_control   = op_ctrl;
  assign mdu_operand_a = op_a;
  assign mdu_operand_b = op_b;

endmodule

`default_nettype wire

// File: tb/tb_cpu_mdu_dispatch.sv
// == tb_cpu_mdu_dispatch : directed self-checking bench for cpu_mdu_dispatch with a behavioural cpu_mdu stub ==
// == rev 1.0 ==
`default_nettype none

module tb_cpu_mdu_dispatch;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        in_valid, in_ready;
  logic [2:0]  in_control;
  logic [31:0] in_operand_a, in_operand_b;
  logic [4:0]  in_rd;
  logic        mdu_start, mdu_ready;
  logic [2:0]  mdu_control;
  logic [31:0] mdu_operand_a, mdu_operand_b, mdu_result;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] got_res[$];
  logic [4:0]  got_rd[$];
  int          starts;

  always #5 clk = ~clk;

  cpu_mdu_dispatch #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
`ifdef MDU_DISPATCH_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_control(in_control),
    .in_operand_a(in_operand_a), .in_operand_b(in_operand_b), .in_rd(in_rd),
    .mdu_start(mdu_start), .mdu_control(mdu_control),
    .mdu_operand_a(mdu_operand_a), .mdu_operand_b(mdu_operand_b),
    .mdu_result(mdu_result), .mdu_ready(mdu_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd)
  );

  // cpu_mdu stand-in: result after a fixed latency, restarts whenever start drops.
  function automatic logic [31:0] mdu_model(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = {32'b0, x} * {32'b0, y};
    case (c)
      3'd0:    return p[31:0];
      3'd3:    return p[63:32];
      3'd4:    return 32'($signed(x) / $signed(y));
      3'd6:    return 32'($signed(x) % $signed(y));
      default: return 32'd0;
    endcase
  endfunction

  int stub_cnt;
  always @(posedge clk) begin
    if (reset || !mdu_start) begin
      stub_cnt   <= 0;
      mdu_ready  <= 1'b0;
      mdu_result <= 32'd0;
    end else if (mdu_ready) begin
      mdu_ready <= 1'b0;
    end else if (stub_cnt == 3) begin
      mdu_ready  <= 1'b1;
      mdu_result <= mdu_model(mdu_control, mdu_operand_a, mdu_operand_b);
    end else begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r);
    in_valid = 1'b1; in_control = c; in_operand_a = x; in_operand_b = y; in_rd = r;
    step();
    in_valid = 1'b0;
  endtask

  task automatic clear_log();
    got_res.delete();
    got_rd.delete();
    starts = 0;
  endtask

  task automatic collect(input int cycles);
    logic prev;
    prev = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (mdu_start && !prev) starts++;
      prev = mdu_start;
      if (out_valid && out_ready) begin
        got_res.push_back(out_result);
        got_rd.push_back(out_rd);
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_control = 3'd0; in_operand_a = 32'd0; in_operand_b = 32'd0; in_rd = 5'd0;
    repeat (3) step();
    reset = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (mdu_start !== 1'b0) begin n_fail++; $display("FAIL reset_mdu_start: got %b expected 0", mdu_start); end
    n_checks++; if (mdu_control !== 3'd0) begin n_fail++; $display("FAIL reset_mdu_control: got %h expected 0", mdu_control); end
    n_checks++; if ({mdu_operand_a, mdu_operand_b} !== 64'd0) begin n_fail++; $display("FAIL reset_operands: got %h %h expected 0 0", mdu_operand_a, mdu_operand_b); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if ({out_result, out_rd} !== 37'd0) begin n_fail++; $display("FAIL reset_out_data: got %h/%0d expected 0/0", out_result, out_rd); end
  endtask

  task automatic test_single_mul();
    out_ready = 1'b1;
    clear_log();
    push(3'd0, 32'd2, 32'd3, 5'd5);
    n_checks++; if (mdu_start !== 1'b0) begin n_fail++; $display("FAIL mul_start_early: got %b expected 0 one edge after accept", mdu_start); end
    step();
    n_checks++; if (mdu_start !== 1'b1) begin n_fail++; $display("FAIL mul_start_timing: got %b expected 1 two edges after accept", mdu_start); end
    n_checks++; if ({mdu_control, mdu_operand_a, mdu_operand_b} !== {3'd0, 32'd2, 32'd3}) begin
      n_fail++; $display("FAIL mul_issue_operands: got ctrl=%0d a=%h b=%h expected 0 2 3", mdu_control, mdu_operand_a, mdu_operand_b);
    end
    collect(20);
    n_checks++; if (got_res.size() != 1) begin n_fail++; $display("FAIL mul_result_count: got %0d expected 1", got_res.size()); end
    else begin
      n_checks++; if ({got_res[0], got_rd[0]} !== {32'd6, 5'd5}) begin n_fail++; $display("FAIL mul_result: got %h/rd%0d expected 6/rd5", got_res[0], got_rd[0]); end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    clear_log();
    push(3'd4, 32'd6, 32'd3, 5'd1);
    push(3'd6, 32'd7, 32'd3, 5'd2);
    collect(40);
    n_checks++; if (got_res.size() != 2) begin n_fail++; $display("FAIL b2b_result_count: got %0d expected 2", got_res.size()); end
    else begin
      n_checks++; if ({got_res[0], got_rd[0]} !== {32'd2, 5'd1}) begin n_fail++; $display("FAIL b2b_first: got %h/rd%0d expected 2/rd1", got_res[0], got_rd[0]); end
      n_checks++; if ({got_res[1], got_rd[1]} !== {32'd1, 5'd2}) begin n_fail++; $display("FAIL b2b_second: got %h/rd%0d expected 1/rd2", got_res[1], got_rd[1]); end
    end
    n_checks++; if (starts != 2) begin n_fail++; $display("FAIL b2b_start_pulses: got %0d expected 2 separate start pulses", starts); end
  endtask

  task automatic test_full_backpressure();
    int waited, unstable;
    out_ready = 1'b0;
    clear_log();
    push(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd3);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_1: got %b expected 1", in_ready); end
    push(3'd0, 32'd1, 32'd1, 5'd4);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_2: got %b expected 1", in_ready); end
    push(3'd0, 32'd2, 32'd2, 5'd6);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_after_3: got %b expected 0", in_ready); end
    waited = 0;
    while (!out_valid && waited < 20) begin step(); waited++; end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_wait_valid: got %b expected 1 within 20 cycles", out_valid); end
    n_checks++; if ({out_result, out_rd} !== {32'h0000_0001, 5'd3}) begin n_fail++; $display("FAIL full_first_result: got %h/rd%0d expected 00000001/rd3", out_result, out_rd); end
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid !== 1'b1 || out_result !== 32'h1 || out_rd !== 5'd3 || in_ready !== 1'b0) unstable++;
    end
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL full_hold_stable: got %0d unstable cycles expected 0", unstable); end
    out_ready = 1'b1;
    collect(60);
    n_checks++; if (got_res.size() != 3) begin n_fail++; $display("FAIL full_result_count: got %0d expected 3", got_res.size()); end
    else begin
      n_checks++; if ({got_res[0], got_rd[0]} !== {32'd1, 5'd3}) begin n_fail++; $display("FAIL full_order0: got %h/rd%0d expected 1/rd3", got_res[0], got_rd[0]); end
      n_checks++; if ({got_res[1], got_rd[1]} !== {32'd1, 5'd4}) begin n_fail++; $display("FAIL full_order1: got %h/rd%0d expected 1/rd4", got_res[1], got_rd[1]); end
      n_checks++; if ({got_res[2], got_rd[2]} !== {32'd4, 5'd6}) begin n_fail++; $display("FAIL full_order2: got %h/rd%0d expected 4/rd6", got_res[2], got_rd[2]); end
    end
  endtask

  task automatic test_reset_mid_issue();
    out_ready = 1'b1;
    clear_log();
    push(3'd4, 32'd8, 32'd2, 5'd7);
    push(3'd0, 32'd3, 32'd3, 5'd8);
    n_checks++; if (mdu_start !== 1'b1) begin n_fail++; $display("FAIL rst_issue_reached: got %b expected 1", mdu_start); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if ({mdu_start, out_valid, in_ready} !== 3'b001) begin
      n_fail++; $display("FAIL rst_mid_issue: got start=%b valid=%b in_ready=%b expected 0 0 1", mdu_start, out_valid, in_ready);
    end
    collect(15);
    n_checks++; if (starts != 0 || got_res.size() != 0) begin n_fail++; $display("FAIL rst_queue_empty: got %0d starts %0d results expected 0 0", starts, got_res.size()); end
    clear_log();
    push(3'd0, 32'd5, 32'd1, 5'd9);
    collect(20);
    n_checks++; if (got_res.size() != 1) begin n_fail++; $display("FAIL rst_after_count: got %0d expected 1", got_res.size()); end
    else begin
      n_checks++; if ({got_res[0], got_rd[0]} !== {32'd5, 5'd9}) begin n_fail++; $display("FAIL rst_after_result: got %h/rd%0d expected 5/rd9", got_res[0], got_rd[0]); end
    end
  endtask

`ifdef MDU_DISPATCH_FLUSH_EN
  task automatic test_flush();
    out_ready = 1'b1;
    clear_log();
    push(3'd4, 32'd9, 32'd3, 5'd1);
    push(3'd0, 32'd4, 32'd4, 5'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if ({mdu_start, in_ready} !== 2'b10) begin n_fail++; $display("FAIL flush_drain: got start=%b in_ready=%b expected 1 0", mdu_start, in_ready); end
    collect(20);
    n_checks++; if (got_res.size() != 0) begin n_fail++; $display("FAIL flush_no_results: got %0d expected 0", got_res.size()); end
    n_checks++; if ({mdu_start, in_ready} !== 2'b01) begin n_fail++; $display("FAIL flush_idle: got start=%b in_ready=%b expected 0 1", mdu_start, in_ready); end
    clear_log();
    push(3'd0, 32'd2, 32'd3, 5'd3);
    collect(20);
    n_checks++; if (got_res.size() != 1) begin n_fail++; $display("FAIL flush_after_count: got %0d expected 1", got_res.size()); end
    else begin
      n_checks++; if ({got_res[0], got_rd[0]} !== {32'd6, 5'd3}) begin n_fail++; $display("FAIL flush_after_result: got %h/rd%0d expected 6/rd3", got_res[0], got_rd[0]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_mul();
    test_back_to_back();
    test_full_backpressure();
    test_reset_mid_issue();
`ifdef MDU_DISPATCH_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
